seg_scan_mux: RTL and testbench

- Parametrised N-digit multiplexed seven-segment scan driver; generalises the fixed two-digit alternator to DIGITS digits.
- Adds a per-digit enable mask that skips disabled digits and a double-buffered valid/ready load path.
- New data applies only at a frame boundary, so a scan frame never mixes old and new digits.
- Sits between display-formatting logic and the board segment/anode pins.

---
 rtl/seg_scan_pkg.sv | 50 +++++
 rtl/seg_prescaler.sv | 21 ++
 rtl/seg_scan_mux.sv | 110 +++++++++++
 tb/tb_seg_scan_mux.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/seg_scan_pkg.sv
// Shared types and helpers for the multiplexed seven-segment scan driver.
// Index helpers work on a 16-bit mask; narrower masks are zero-extended by the caller.
package seg_scan_pkg;

    localparam int DEF_DIGITS = 4;
    localparam int DEF_SEG_W  = 7;
    localparam int DEF_FREQ   = 15000;
    localparam int MAX_DIGITS = 16;
    localparam int IDX_W      = 4;

    typedef logic [MAX_DIGITS-1:0] mask_t;
    typedef logic [IDX_W-1:0]      idx_t;

    typedef struct packed {
        idx_t idx;
        logic wrap;
        logic found;
    } next_t;

    function automatic idx_t lowest_enabled(input mask_t mask);
        idx_t r = '0;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (mask[i]) r = idx_t'(i);
        end
        return r;
    endfunction

    // Lowest enabled index above cur; if none, wrap to the lowest enabled index overall.
    function automatic next_t next_enabled(input mask_t mask, input idx_t cur);
        next_t r;
        r.idx   = cur;
        r.wrap  = 1'b1;
        r.found = |mask;
        for (int i = MAX_DIGITS - 1; i >= 0; i--) begin
            if (mask[i] && (idx_t'(i) > cur)) begin
                r.idx  = idx_t'(i);
                r.wrap = 1'b0;
            end
        end
        if (r.wrap && r.found) r.idx = lowest_enabled(mask);
        return r;
    endfunction

    function automatic mask_t onehot(input idx_t idx);
        mask_t r = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/seg_prescaler.sv
// Free-running dwell counter; tick is high for one cycle every FREQ+1 cycles.
module seg_prescaler #(
    parameter int FREQ  = 15000,
    parameter int CBITS = $clog2(FREQ + 1)
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    logic [CBITS-1:0] r_cnt;

    assign tick = (r_cnt == CBITS'(FREQ));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else        r_cnt <= tick ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/seg_scan_mux.sv
// N-digit seven-segment scan driver with enable mask and a double-buffered load path.
// A loaded frame waits in the shadow buffer and is applied only when the scan wraps.
module seg_scan_mux
    import seg_scan_pkg::*;
#(
    parameter int DIGITS = DEF_DIGITS,
    parameter int SEG_W  = DEF_SEG_W,
    parameter int FREQ   = DEF_FREQ,
    parameter int CBITS  = $clog2(FREQ + 1),
    parameter int DSEL_W = $clog2(DIGITS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [DIGITS*SEG_W-1:0] data_in,
    input  logic [DIGITS-1:0]       en_in,
    input  logic                    data_valid,
    output logic                    data_ready,
    output logic [SEG_W-1:0]        segment,
    output logic [DIGITS-1:0]       anode,
    output logic [DSEL_W-1:0]       digit_sel,
    output logic                    tick,
    output logic                    frame_start
);

    logic [DIGITS*SEG_W-1:0] r_frame;
    logic [DIGITS*SEG_W-1:0] r_shadow;
    logic [DIGITS-1:0]       r_mask;
    logic [DIGITS-1:0]       r_shadow_mask;
    logic                    r_pending;
    logic [DSEL_W-1:0]       r_sel;
    logic [SEG_W-1:0]        r_seg;
    logic [DIGITS-1:0]       r_anode;

    logic                    w_tick;
    logic                    w_accept;
    logic                    w_apply;
    logic                    w_next_found;
    next_t                   w_step;
    idx_t                    w_next_idx;
    logic [DIGITS*SEG_W-1:0] w_src;

    seg_prescaler #(
        .FREQ (FREQ),
        .CBITS(CBITS)
    ) u_prescaler (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (w_tick)
    );

    assign w_step   = next_enabled(mask_t'(r_mask), idx_t'(r_sel));
    assign w_accept = data_valid && !r_pending;
    assign w_apply  = w_tick && w_step.wrap && r_pending;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_next_idx   = w_step.idx;
        w_next_found = w_step.found;
        w_src        = r_frame;
        if (w_apply) begin
            w_next_idx   = lowest_enabled(mask_t'(r_shadow_mask));
            w_next_found = |r_shadow_mask;
            w_src        = r_shadow;
        end
    end

    // NOTE: the frame buffers are plain flops, so reset clears them; a frame must not survive reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame       <= '0;
            r_shadow      <= '0;
            r_mask        <= '0;
            r_shadow_mask <= '0;
            r_pending     <= 1'b0;
            r_sel         <= '0;
            r_seg         <= '0;
            r_anode       <= '0;
        end else begin
            if (w_accept) begin
                r_shadow      <= data_in;
                r_shadow_mask <= en_in;
                r_pending     <= 1'b1;
            end else if (w_apply) begin
                r_pending     <= 1'b0;
            end
            if (w_apply) begin
                r_frame <= r_shadow;
                r_mask  <= r_shadow_mask;
            end
            if (w_tick) begin
                if (w_next_found) begin
                    r_sel   <= DSEL_W'(w_next_idx);
                    r_seg   <= w_src[w_next_idx*SEG_W +: SEG_W];
                    r_anode <= DIGITS'(onehot(w_next_idx));
                end else begin
                    r_seg   <= '0;
                    r_anode <= '0;
                end
            end
        end
    end

    assign data_ready  = !r_pending;
    assign segment     = r_seg;
    assign anode       = r_anode;
    assign digit_sel   = r_sel;
    assign tick        = w_tick;
    assign frame_start = w_tick && w_step.wrap;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Scoreboard bench for seg_scan_mux: stimulus queues the expected result of each tick,
// a monitor pops one entry per tick and checks frame_start, then the registered outputs.
module tb_seg_scan_mux;

    localparam int DIGITS = 4;
    localparam int SEG_W  = 7;
    localparam int FREQ   = 3;

    typedef struct {
        logic       fs;
        logic [3:0] an;
        logic [6:0] seg;
        logic [1:0] sel;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [27:0] data_in;
    logic [3:0]  en_in;
    logic        data_valid;
    logic        data_ready;
    logic [6:0]  segment;
    logic [3:0]  anode;
    logic [1:0]  digit_sel;
    logic        tick;
    logic        frame_start;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    seg_scan_mux #(
        .DIGITS(DIGITS),
        .SEG_W (SEG_W),
        .FREQ  (FREQ)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .data_in    (data_in),
        .en_in      (en_in),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .segment    (segment),
        .anode      (anode),
        .digit_sel  (digit_sel),
        .tick       (tick),
        .frame_start(frame_start)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [27:0] pk(input logic [6:0] d3, input logic [6:0] d2,
                                       input logic [6:0] d1, input logic [6:0] d0);
        return {d3, d2, d1, d0};
    endfunction

    // Monitor: on each tick pop one expectation; outputs are checked one cycle later.
    initial begin : monitor
        exp_t cur;
        bit   post_pend = 0;
        bit   have_prev = 0;
        int   since     = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                post_pend = 0;
                have_prev = 0;
                since     = 0;
            end else begin
                if (post_pend) begin
                    check("anode", anode, cur.an);
                    check("segment", segment, cur.seg);
                    check("digit_sel", digit_sel, cur.sel);
                    post_pend = 0;
                end
                since++;
                if (tick) begin
                    if (have_prev) check("tick_period", since, FREQ + 1);
                    have_prev = 1;
                    since     = 0;
                    if (exp_q.size() == 0) begin
                        check("unexpected_tick", 0, 1);
                    end else begin
                        cur = exp_q.pop_front();
                        check("frame_start", frame_start, cur.fs);
                        post_pend = 1;
                    end
                end else if (frame_start) begin
                    check("frame_start_no_tick", frame_start, 0);
                end
            end
        end
    end

    // Queue the expected result of the next tick and return at that tick's negedge.
    task automatic step(input logic fs, input logic [3:0] an, input logic [6:0] seg,
                        input logic [1:0] sel);
        exp_t e;
        bit   seen = 0;
        e.fs  = fs;
        e.an  = an;
        e.seg = seg;
        e.sel = sel;
        exp_q.push_back(e);
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            seen = tick;
        end
        if (!seen) check("tick_timeout", 0, 1);
    endtask

    // on_tick=1 drives the offer in the current cycle (the tick cycle just observed).
    task automatic load(input logic [27:0] d, input logic [3:0] en, input bit on_tick);
        if (!on_tick) @(negedge clk);
        check("ready_before_load", data_ready, 1);
        data_in    = d;
        en_in      = en;
        data_valid = 1'b1;
        @(negedge clk);
        data_valid = 1'b0;
        check("ready_after_accept", data_ready, 0);
    endtask

    // Called at the negedge of the tick that applies a pending frame.
    task automatic ready_return();
        check("ready_at_apply", data_ready, 0);
        @(negedge clk);
        check("ready_after_apply", data_ready, 1);
    endtask

    initial begin : watchdog
        #20000;
        $display("FAIL watchdog actual=timeout required=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin : stimulus
        rst_n      = 1'b0;
        data_in    = '0;
        en_in      = '0;
        data_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_segment", segment, 0);
        check("rst_anode", anode, 0);
        check("rst_digit_sel", digit_sel, 0);
        check("rst_ready", data_ready, 1);
        check("rst_tick", tick, 0);
        #2 rst_n = 1'b1;

        // Idle with an empty mask: every tick is a wrap, nothing driven.
        step(1, 4'b0000, 7'h00, 2'd0);
        step(1, 4'b0000, 7'h00, 2'd0);

        // All digits enabled; applied at the next tick.
        load(pk(7'h08, 7'h04, 7'h02, 7'h01), 4'b1111, 0);
        step(1, 4'b0001, 7'h01, 2'd0);
        ready_return();
        step(0, 4'b0010, 7'h02, 2'd1);

        // Mid-frame load at digit 1: old digits 2,3 finish the frame first.
        load(pk(7'h7F, 7'h7F, 7'h7F, 7'h7F), 4'b1111, 0);
        step(0, 4'b0100, 7'h04, 2'd2);
        step(0, 4'b1000, 7'h08, 2'd3);
        step(1, 4'b0001, 7'h7F, 2'd0);
        ready_return();
        step(0, 4'b0010, 7'h7F, 2'd1);

        // Sparse mask 1010.
        load(pk(7'h44, 7'h33, 7'h22, 7'h11), 4'b1010, 0);
        step(0, 4'b0100, 7'h7F, 2'd2);
        step(0, 4'b1000, 7'h7F, 2'd3);
        step(1, 4'b0010, 7'h22, 2'd1);
        ready_return();
        step(0, 4'b1000, 7'h44, 2'd3);
        step(1, 4'b0010, 7'h22, 2'd1);
        step(0, 4'b1000, 7'h44, 2'd3);

        // Offer on a wrap tick with nothing pending: applies one frame later.
        step(1, 4'b0010, 7'h22, 2'd1);
        load(pk(7'h0D, 7'h0C, 7'h0B, 7'h0A), 4'b0100, 1);
        step(0, 4'b1000, 7'h44, 2'd3);
        step(1, 4'b0100, 7'h0C, 2'd2);
        ready_return();
        step(1, 4'b0100, 7'h0C, 2'd2);

        // Reset while a frame is pending at digit 2: shadow is lost.
        load(pk(7'h73, 7'h72, 7'h71, 7'h70), 4'b1111, 0);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_segment", segment, 0);
        check("midrst_anode", anode, 0);
        check("midrst_digit_sel", digit_sel, 0);
        check("midrst_ready", data_ready, 1);
        check("midrst_frame_start", frame_start, 0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        step(1, 4'b0000, 7'h00, 2'd0);
        step(1, 4'b0000, 7'h00, 2'd0);

        // Single enabled digit after reset: same digit every tick, frame_start each tick.
        load(pk(7'h00, 7'h00, 7'h00, 7'h55), 4'b0001, 0);
        step(1, 4'b0001, 7'h55, 2'd0);
        ready_return();
        step(1, 4'b0001, 7'h55, 2'd0);

        @(negedge clk);
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
